// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: the global edge-mode encoding.
package edge_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_chan.sv
// One detector channel: input synchroniser, previous-sample register, event strobe,
// sticky flag and saturating event counter.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             flag_clr,
  input  logic             cnt_clr,
  output logic             pulse,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s, rise, fall, ev;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = s;
    rise   = s & ~prev_q;
    fall   = ~s & prev_q;
    ev     = 1'b0;
    if (en) begin
      case (mode)
        MODE_RISE: ev = rise;
        MODE_FALL: ev = fall;
        MODE_BOTH: ev = rise | fall;
        default:   ev = 1'b0;
      endcase
    end
    pulse_d = ev;
    // A new event beats a simultaneous clear so no event is ever lost.
    flag_d  = ev | (flag_q & ~flag_clr);
    cnt_d   = cnt_q;
    if (ev) begin
      if (cnt_clr)
        cnt_d = CNT_W'(1);
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;
  assign flag  = flag_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge/change detector: WIDTH independent channels sharing a post-reset
// warm-up gate and a registered counter readout mux.
module edge_detect_mc
  import edge_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int SEL_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] flag,
  input  logic [WIDTH-1:0] flag_clr,
  input  logic             cnt_clr,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  localparam int WU_MAX = SYNC_STAGES + 1;
  localparam int WU_W   = $clog2(WU_MAX + 1);

  logic [WU_W-1:0]  wu_q, wu_d;
  logic             warm_en;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic [CNT_W-1:0] cnt_w [WIDTH];

  // Events stay masked until the synchroniser and prev registers hold real samples.
  assign warm_en = (wu_q == WU_W'(WU_MAX));

  always_comb begin
    wu_d = warm_en ? wu_q : wu_q + WU_W'(1);
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      edge_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din[gi]),
        .en       (warm_en),
        .mode     (mode),
        .flag_clr (flag_clr[gi]),
        .cnt_clr  (cnt_clr),
        .pulse    (pulse[gi]),
        .flag     (flag[gi]),
        .cnt      (cnt_w[gi])
      );
    end
  endgenerate

  // Selects beyond the last channel read as zero rather than aliasing.
  always_comb begin
    cnt_out_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (32'(cnt_sel) == i)
        cnt_out_d = cnt_w[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wu_q      <= '0;
      cnt_out_q <= '0;
    end else begin
      wu_q      <= wu_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  assign cnt_out = cnt_out_q;

endmodule
